// File: rtl/rsa_core_arbiter.sv
// Round-robin arbiter sharing one RSA core between NUM_REQ requesters.
// Ports: i_req_* from requesters, o_req_* status back, o_core_*/i_core_* to core.
module rsa_core_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_start,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_d,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_n,
  output logic [NUM_REQ-1:0]       o_req_pending,
  output logic [NUM_REQ-1:0]       o_req_grant,
  output logic [NUM_REQ-1:0]       o_req_done,
  output logic [WIDTH-1:0]         o_result,
  output logic                     o_core_start,
  output logic [WIDTH-1:0]         o_core_a,
  output logic [WIDTH-1:0]         o_core_d,
  output logic [WIDTH-1:0]         o_core_n,
  input  logic [WIDTH-1:0]         i_core_result,
  input  logic                     i_core_finished
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]      rr_q, rr_d;
  logic [PW-1:0]      gidx_q, gidx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [WIDTH-1:0]   n_q, n_d;
  logic [WIDTH-1:0]   res_q, res_d;

  logic [NUM_REQ-1:0] sel;
  logic [PW-1:0]      sel_idx;
  logic               sel_vld;
  logic [PW:0]        idx;

  // First pending bit at or above rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    sel_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_q} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_REQ))
        idx = idx - (PW+1)'(NUM_REQ);
      if (!sel_vld && pend_q[idx[PW-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = idx[PW-1:0];
      end
    end
    if (sel_vld)
      sel[sel_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    // A start is dropped while that requester is already pending or owns the core.
    pend_d       = pend_q | (i_req_start & ~grant_q);
    grant_d      = grant_q;
    rr_d         = rr_q;
    gidx_d       = gidx_q;
    a_d          = a_q;
    d_d          = d_q;
    n_d          = n_q;
    res_d        = res_q;
    o_core_start = 1'b0;
    o_req_done   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (sel_vld) begin
          grant_d = sel;
          pend_d  = pend_d & ~sel;
          gidx_d  = sel_idx;
          a_d     = i_req_a[sel_idx*WIDTH +: WIDTH];
          d_d     = i_req_d[sel_idx*WIDTH +: WIDTH];
          n_d     = i_req_n[sel_idx*WIDTH +: WIDTH];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_core_start = 1'b1;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (i_core_finished) begin
          res_d   = i_core_result;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        o_req_done = grant_q;
        grant_d    = '0;
        if (gidx_q == PW'(NUM_REQ-1))
          rr_d = '0;
        else
          rr_d = gidx_q + PW'(1);
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      gidx_q  <= '0;
      a_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
      a_q     <= a_d;
      d_q     <= d_d;
      n_q     <= n_d;
      res_q   <= res_d;
    end
  end

  assign o_req_pending = pend_q;
  assign o_req_grant   = grant_q;
  assign o_result      = res_q;
  assign o_core_a      = a_q;
  assign o_core_d      = d_q;
  assign o_core_n      = n_q;

endmodule
